// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: serial adder state encoding and the
// digit-counter width helper.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for ndig digits; a 1-digit operand still needs a 1-bit counter.
  function automatic int cnt_w(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/fa_digit.sv
// DIGIT_W-bit combinational ripple of full adders; also exposes the carry into
// the MSB so the caller can form signed overflow.
module fa_digit #(
  parameter int DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               ci,
  output logic [DIGIT_W-1:0] s,
  output logic               co,
  output logic               cmsb
);

  logic [DIGIT_W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT_W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co   = c[DIGIT_W];
  assign cmsb = c[DIGIT_W-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder, DIGIT_W bits per clock, LSB digit first, start/busy/done
// handshake. Define SERIAL_ADDER_SUB_EN to add the sub port (a - b).
module serial_adder
  import arith_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DIGIT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT_W;
  localparam int CW   = cnt_w(NDIG);

  if (WIDTH % DIGIT_W != 0) begin : g_bad_digit
    $error("serial_adder: DIGIT_W must divide WIDTH");
  end

  state_t             state;
  logic [WIDTH-1:0]   ra, rb;
  logic               carry;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   b_cap;
  logic               c_cap;
  logic [DIGIT_W-1:0] dsum;
  logic               dco, dcm;

`ifdef SERIAL_ADDER_SUB_EN
  // a - b = a + ~b + 1; cin is ignored when subtracting.
  assign b_cap = sub ? ~b : b;
  assign c_cap = sub | cin;
`else
  assign b_cap = b;
  assign c_cap = cin;
`endif

  fa_digit #(.DIGIT_W(DIGIT_W)) u_fa (
    .a    (ra[DIGIT_W-1:0]),
    .b    (rb[DIGIT_W-1:0]),
    .ci   (carry),
    .s    (dsum),
    .co   (dco),
    .cmsb (dcm)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            ra    <= a;
            rb    <= b_cap;
            carry <= c_cap;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          ra    <= ra >> DIGIT_W;
          rb    <= rb >> DIGIT_W;
          // Digit sums enter at the MSB end so the LSB digit lands at bit 0 last.
          sum   <= WIDTH'({dsum, sum} >> DIGIT_W);
          carry <= dco;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(NDIG - 1)) begin
            cout  <= dco;
            ovf   <= dco ^ dcm;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
